// File: rtl/dll_lock_seq.sv
// RX DLL lock sequencer: settle delay, lock request with timeout, retry with backoff, locked/fail status.
// Build option DLL_LOCK_SEQ_LOSS_CNT_EN adds lock_loss_cnt[7:0] and lock_loss_pulse outputs.
module dll_lock_seq #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int BACKOFF_CYC = 8,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cal_en,
  input  logic       ms_nsl,
  output logic       ms_rx_dll_lock_req,
  output logic       sl_rx_dll_lock_req,
  input  logic       ms_rx_dll_lock,
  input  logic       sl_rx_dll_lock,
  output logic       dll_locked,
  output logic       dll_fail,
  output logic [1:0] retry_cnt
`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic       lock_loss_pulse
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_REQ     = 3'd2,
    S_LOCKED  = 3'd3,
    S_BACKOFF = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYC - 1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             sel_q, sel_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       ms_sync_q, ms_sync_d;
  logic [1:0]       sl_sync_q, sl_sync_d;
  logic             ms_req_q, ms_req_d;
  logic             sl_req_q, sl_req_d;
  logic             locked_q, locked_d;
  logic             fail_q, fail_d;
  logic             lock_s;
  logic             req_on;
  logic             retry_go;

  always_comb begin
    ms_sync_d = {ms_sync_q[0], ms_rx_dll_lock};
    sl_sync_d = {sl_sync_q[0], sl_rx_dll_lock};
    lock_s    = sel_q ? ms_sync_q[1] : sl_sync_q[1];

    state_d  = state_q;
    timer_d  = timer_q;
    sel_d    = sel_q;
    retry_d  = retry_q;
    retry_go = 1'b0;

    if (!cal_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          sel_d   = ms_nsl;
          retry_d = 2'd0;
          timer_d = '0;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            timer_d = '0;
            state_d = S_REQ;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_REQ: begin
          // A lock seen on the last timeout count still wins over the retry.
          if (lock_s) begin
            state_d = S_LOCKED;
          end else if (timer_q == TIMEOUT_LAST) begin
            retry_go = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_LOCKED: begin
          if (!lock_s) begin
            retry_go = 1'b1;
          end
        end
        S_BACKOFF: begin
          if (timer_q == BACKOFF_LAST) begin
            timer_d = '0;
            state_d = S_REQ;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (retry_go) begin
        if (retry_q == RETRY_MAX) begin
          state_d = S_FAIL;
        end else begin
          retry_d = retry_q + 2'd1;
          timer_d = '0;
          state_d = S_BACKOFF;
        end
      end
    end

    // Request follows the current state, so it trails the state by one clock on both edges.
    req_on   = cal_en && ((state_q == S_REQ) || (state_q == S_LOCKED));
    ms_req_d = req_on && sel_q;
    sl_req_d = req_on && !sel_q;
    locked_d = (state_d == S_LOCKED);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      sel_q     <= 1'b0;
      retry_q   <= 2'd0;
      ms_sync_q <= 2'b00;
      sl_sync_q <= 2'b00;
      ms_req_q  <= 1'b0;
      sl_req_q  <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sel_q     <= sel_d;
      retry_q   <= retry_d;
      ms_sync_q <= ms_sync_d;
      sl_sync_q <= sl_sync_d;
      ms_req_q  <= ms_req_d;
      sl_req_q  <= sl_req_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
    end
  end

  assign ms_rx_dll_lock_req = ms_req_q;
  assign sl_rx_dll_lock_req = sl_req_q;
  assign dll_locked         = locked_q;
  assign dll_fail           = fail_q;
  assign retry_cnt          = retry_q;

`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       loss_pulse_q, loss_pulse_d;

  always_comb begin
    loss_pulse_d = cal_en && (state_q == S_LOCKED) && !lock_s;
    loss_cnt_d   = loss_cnt_q;
    if (loss_pulse_d && (loss_cnt_q != 8'hff)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q   <= 8'd0;
      loss_pulse_q <= 1'b0;
    end else begin
      loss_cnt_q   <= loss_cnt_d;
      loss_pulse_q <= loss_pulse_d;
    end
  end

  assign lock_loss_cnt   = loss_cnt_q;
  assign lock_loss_pulse = loss_pulse_q;
`endif

endmodule

// File: tb/tb_dll_lock_seq.sv
// Testbench for dll_lock_seq: phase/deadline reference model feeds an expected-output queue,
// a negedge monitor pops and compares every cycle; directed latency checks on top.
module tb_dll_lock_seq;

  localparam int SETTLE_CYC  = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int BACKOFF_CYC = 8;
  localparam int MAX_RETRY   = 3;

  localparam int P_IDLE    = 0;
  localparam int P_SETTLE  = 1;
  localparam int P_REQ     = 2;
  localparam int P_LOCKED  = 3;
  localparam int P_BACKOFF = 4;
  localparam int P_FAIL    = 5;

  typedef struct packed {
    logic       ms_req;
    logic       sl_req;
    logic       locked;
    logic       fail;
    logic [1:0] retry;
    logic [7:0] loss_cnt;
    logic       loss_pulse;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cal_en = 1'b0;
  logic       ms_nsl = 1'b0;
  logic       ms_rx_dll_lock = 1'b0;
  logic       sl_rx_dll_lock = 1'b0;
  logic       ms_rx_dll_lock_req;
  logic       sl_rx_dll_lock_req;
  logic       dll_locked;
  logic       dll_fail;
  logic [1:0] retry_cnt;
`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
  logic       lock_loss_pulse;
`endif

  dll_lock_seq dut (
    .clk                (clk),
    .rst                (rst),
    .cal_en             (cal_en),
    .ms_nsl             (ms_nsl),
    .ms_rx_dll_lock_req (ms_rx_dll_lock_req),
    .sl_rx_dll_lock_req (sl_rx_dll_lock_req),
    .ms_rx_dll_lock     (ms_rx_dll_lock),
    .sl_rx_dll_lock     (sl_rx_dll_lock),
    .dll_locked         (dll_locked),
    .dll_fail           (dll_fail),
    .retry_cnt          (retry_cnt)
`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
    ,
    .lock_loss_cnt      (lock_loss_cnt),
    .lock_loss_pulse    (lock_loss_pulse)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;   // index of the next rising edge
  out_t exp_q[$];

  // Reference model: phase plus the edge at which it was entered; durations are edge counts.
  int   m_ph = P_IDLE;
  int   m_start = 0;
  bit   m_side = 1'b0;
  int   m_retry = 0;
  int   m_loss = 0;
  bit   m_pulse = 1'b0;
  bit   ms_hist[2] = '{1'b0, 1'b0};
  bit   sl_hist[2] = '{1'b0, 1'b0};

  task automatic enter(input int p);
    m_ph    = p;
    m_start = cyc;
  endtask

  task automatic retry_decide();
    if (m_retry == MAX_RETRY) begin
      enter(P_FAIL);
    end else begin
      m_retry++;
      enter(P_BACKOFF);
    end
  endtask

  task automatic model_step(output out_t e);
    bit lk;
    bit req_now;
    int n;
    e = '0;
    if (rst) begin
      m_ph = P_IDLE; m_side = 1'b0; m_retry = 0; m_loss = 0; m_pulse = 1'b0;
      ms_hist = '{1'b0, 1'b0};
      sl_hist = '{1'b0, 1'b0};
    end else begin
      // lock value the sequencer acts on is the pin value from two edges ago
      lk = m_side ? ms_hist[1] : sl_hist[1];
      ms_hist[1] = ms_hist[0]; ms_hist[0] = ms_rx_dll_lock;
      sl_hist[1] = sl_hist[0]; sl_hist[0] = sl_rx_dll_lock;
      req_now  = cal_en && (m_ph == P_REQ || m_ph == P_LOCKED);
      e.ms_req = req_now && m_side;
      e.sl_req = req_now && !m_side;
      m_pulse  = 1'b0;
      n = cyc - m_start;
      if (!cal_en) begin
        m_ph = P_IDLE;
      end else begin
        case (m_ph)
          P_IDLE:    begin m_side = ms_nsl; m_retry = 0; enter(P_SETTLE); end
          P_SETTLE:  if (n == SETTLE_CYC) enter(P_REQ);
          P_REQ:     if (lk) enter(P_LOCKED); else if (n == TIMEOUT_CYC) retry_decide();
          P_LOCKED:  if (!lk) begin m_pulse = 1'b1; if (m_loss < 255) m_loss++; retry_decide(); end
          P_BACKOFF: if (n == BACKOFF_CYC) enter(P_REQ);
          default:   ;
        endcase
      end
      e.locked = (m_ph == P_LOCKED);
      e.fail   = (m_ph == P_FAIL);
      e.retry  = 2'(m_retry);
    end
`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
    e.loss_cnt   = 8'(m_loss);
    e.loss_pulse = m_pulse;
`endif
  endtask

  task automatic tick();
    out_t e;
    @(posedge clk);
    model_step(e);
    exp_q.push_back(e);
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic wait_phase(input int p, input int budget, input string nm);
    int n = 0;
    while (m_ph != p && n < budget) begin tick(); n++; end
    chk(nm, 16'(m_ph), 16'(p));
  endtask

  // Monitor: one expected vector per clock edge.
  initial begin
    out_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '0;
        a.ms_req = ms_rx_dll_lock_req;
        a.sl_req = sl_rx_dll_lock_req;
        a.locked = dll_locked;
        a.fail   = dll_fail;
        a.retry  = retry_cnt;
`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
        a.loss_cnt   = lock_loss_cnt;
        a.loss_pulse = lock_loss_pulse;
`endif
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL scoreboard: cycle %0d got req=%b%b lk=%b fail=%b retry=%0d loss=%0d/%b want req=%b%b lk=%b fail=%b retry=%0d loss=%0d/%b",
                   cyc - 1, a.ms_req, a.sl_req, a.locked, a.fail, a.retry, a.loss_cnt, a.loss_pulse,
                   e.ms_req, e.sl_req, e.locked, e.fail, e.retry, e.loss_cnt, e.loss_pulse);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_sl;
    int hi_ms;
    int n;
    int lowc;

    // reset
    rst = 1'b1; cal_en = 1'b0;
    run(2);
    chk("reset_state", 16'({ms_rx_dll_lock_req, sl_rx_dll_lock_req, dll_locked, dll_fail, retry_cnt}), 16'h0);
    rst = 1'b0;
    run(1);

    // master normal lock: cal_en sampled at k=0
    cal_en = 1'b1; ms_nsl = 1'b1;
    tick();
    for (int k = 1; k <= 23; k++) begin
      if (k == 21) ms_rx_dll_lock = 1'b1;
      tick();
      if (k == 16) chk("req_before_17", 16'(ms_rx_dll_lock_req), 16'h0);
      if (k == 17) chk("req_at_17", 16'({ms_rx_dll_lock_req, sl_rx_dll_lock_req}), 16'h2);
      if (k == 22) chk("locked_before_23", 16'(dll_locked), 16'h0);
      if (k == 23) chk("locked_at_23", 16'({dll_locked, retry_cnt}), 16'h4);
    end

    // lock loss, backoff, relock
    run($urandom_range(5, 20));
    ms_rx_dll_lock = 1'b0;
    run(2);
    chk("locked_held_2", 16'(dll_locked), 16'h1);
    tick();
    chk("locked_drop_3", 16'(dll_locked), 16'h0);
    tick();
    lowc = 0; n = 0;
    while (ms_rx_dll_lock_req == 1'b0 && n < 30) begin lowc++; tick(); n++; end
    chk("backoff_len", 16'(lowc + 1 - 1), 16'(BACKOFF_CYC));
    chk("retry_after_loss", 16'(retry_cnt), 16'h1);
    ms_rx_dll_lock = 1'b1;
    run(4);
    chk("relocked", 16'(dll_locked), 16'h1);
`ifdef DLL_LOCK_SEQ_LOSS_CNT_EN
    chk("loss_cnt_1", 16'(lock_loss_cnt), 16'h1);
`endif

    // abort during LOCKED, then re-enable
    cal_en = 1'b0; ms_rx_dll_lock = 1'b0;
    tick();
    chk("abort_locked", 16'({ms_rx_dll_lock_req, sl_rx_dll_lock_req, dll_locked, dll_fail, retry_cnt}), 16'h1);
    cal_en = 1'b1;
    tick();
    chk("restart_retry0", 16'(retry_cnt), 16'h0);

    // abort during REQ
    wait_phase(P_REQ, 40, "reach_req");
    run(3);
    cal_en = 1'b0;
    tick();
    chk("abort_req", 16'({ms_rx_dll_lock_req, sl_rx_dll_lock_req, dll_locked, dll_fail}), 16'h0);

    // slave side: four timeouts to FAIL while ms_nsl toggles
    ms_nsl = 1'b0; sl_rx_dll_lock = 1'b0;
    cal_en = 1'b1;
    tick();
    hi_sl = 0; hi_ms = 0; n = 0;
    while (m_ph != P_FAIL && n < 700) begin
      ms_nsl = 1'($urandom_range(0, 1));
      tick();
      hi_sl += int'(sl_rx_dll_lock_req);
      hi_ms += int'(ms_rx_dll_lock_req);
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      hi_sl += int'(sl_rx_dll_lock_req);
      hi_ms += int'(ms_rx_dll_lock_req);
    end
    chk("sl_req_high_cycles", 16'(hi_sl), 16'(4 * TIMEOUT_CYC));
    chk("ms_req_never", 16'(hi_ms), 16'h0);
    chk("fail_state", 16'({dll_fail, retry_cnt}), 16'h7);

    // abort during FAIL
    cal_en = 1'b0;
    tick();
    chk("abort_fail", 16'({dll_fail, retry_cnt}), 16'h3);

    // lock_s rises on the last timeout count
    ms_nsl = 1'b1; cal_en = 1'b1;
    wait_phase(P_REQ, 40, "reach_req_edge");
    n = 0;
    while (cyc < m_start + TIMEOUT_CYC - 2 && n < 100) begin tick(); n++; end
    ms_rx_dll_lock = 1'b1;
    run(2);
    chk("edge_not_yet", 16'(dll_locked), 16'h0);
    tick();
    chk("edge_lock_wins", 16'({dll_locked, dll_fail, retry_cnt}), 16'h8);

    // synchronous reset during LOCKED
    run(3);
    rst = 1'b1;
    tick();
    chk("rst_locked", 16'({ms_rx_dll_lock_req, sl_rx_dll_lock_req, dll_locked, dll_fail, retry_cnt}), 16'h0);
    rst = 1'b0;

    // randomized operation
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) cal_en = ~cal_en;
      else if (!cal_en && $urandom_range(0, 3) == 0) cal_en = 1'b1;
      if ($urandom_range(0, 39) == 0) ms_rx_dll_lock = ~ms_rx_dll_lock;
      if ($urandom_range(0, 39) == 0) sl_rx_dll_lock = ~sl_rx_dll_lock;
      ms_nsl = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; cal_en = 1'b0;
    run(3);

    n = 0;
    while (exp_q.size() != 0 && n < 5) begin @(negedge clk); n++; end
    #1;
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
